// File: rtl/add_chain_pipe.sv
// Add-constant pipeline: STAGES register stages, stage i adds K(i).
// Ports: clk/rst, in_* ready/valid input, out_* ready/valid output, out_ovf, occupancy.
module add_chain_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter logic [STAGES*WIDTH-1:0] K_VEC = {32'd10, 32'd3, 32'd5},
  parameter bit SAT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf,
  output logic [3:0]       occupancy
);

  logic [WIDTH-1:0]  d  [STAGES];
  logic [WIDTH-1:0]  nd [STAGES];
  logic [STAGES-1:0] v, o, adv, nv, no;
  logic [3:0]        occ;

  // MSB of the result is the carry; low bits are wrapped or clamped.
  function automatic logic [WIDTH:0] f(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] k
  );
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, k};
    if (SAT && s[WIDTH])
      s[WIDTH-1:0] = '1;
    return s;
  endfunction

  // A stage may load when it is empty or its successor moves on.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = out_ready | ~v[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--)
      adv[i] = adv[i+1] | ~v[i];
  end

  always_comb begin
    logic [WIDTH:0] s;
    for (int i = 0; i < STAGES; i++)
      nd[i] = '0;
    nv = '0;
    no = '0;
    s  = f(in_data, K_VEC[0 +: WIDTH]);
    nd[0] = s[WIDTH-1:0];
    nv[0] = in_valid;
    no[0] = s[WIDTH];
    for (int i = 1; i < STAGES; i++) begin
      s     = f(d[i-1], K_VEC[i*WIDTH +: WIDTH]);
      nd[i] = s[WIDTH-1:0];
      nv[i] = v[i-1];
      no[i] = o[i-1] | s[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++)
        d[i] <= '0;
      v <= '0;
      o <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (adv[i]) begin
          d[i] <= nd[i];
          v[i] <= nv[i];
          o[i] <= no[i];
        end
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++)
      occ = occ + 4'(v[i]);
  end

  assign in_ready  = adv[0];
  assign out_data  = d[STAGES-1];
  assign out_valid = v[STAGES-1];
  assign out_ovf   = o[STAGES-1];
  assign occupancy = occ;

endmodule

// File: tb/tb_add_chain_pipe.sv
// Directed bench for add_chain_pipe: wrap and saturating instances side by side.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_add_chain_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_data;
  logic [3:0]  occupancy;
  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [31:0] s_out_data;
  logic [3:0]  s_occupancy;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  add_chain_pipe #(.SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ovf(out_ovf), .occupancy(occupancy)
  );

  add_chain_pipe #(.SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ovf(s_out_ovf), .occupancy(s_occupancy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid);
    else pass_cnt++;
    total++;
    if (occupancy !== 4'd0) $display("FAIL rst_occ: got %0d want 0", occupancy);
    else pass_cnt++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready);
    else pass_cnt++;
    total++;
    if (out_data !== 32'd0) $display("FAIL rst_data: got %h want 0", out_data);
    else pass_cnt++;
  endtask

  task automatic test_single();
    bit seen;
    out_ready = 1'b1;
    in_data = 32'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL lat_early: got %b want 0", out_valid);
    else pass_cnt++;
    step();
    total++;
    if (out_valid !== 1'b1) $display("FAIL lat_valid: got %b want 1", out_valid);
    else pass_cnt++;
    total++;
    if (out_data !== 32'd23) $display("FAIL single5: got %0d want 23", out_data);
    else pass_cnt++;
    total++;
    if (out_ovf !== 1'b0) $display("FAIL single5_ovf: got %b want 0", out_ovf);
    else pass_cnt++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL pulse_once: got %b want 0", out_valid);
    else pass_cnt++;
    in_data = 32'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid) seen = 1'b1;
      else step();
    end
    total++;
    if (!seen) $display("FAIL single7: got timeout want 25");
    else if (out_data !== 32'd25) $display("FAIL single7: got %0d want 25", out_data);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    logic [31:0] exp_v [4];
    bit xin;
    exp_v = '{32'd19, 32'd20, 32'd21, 32'd22};
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_data = 32'(k);
      step();
    end
    in_data = 32'd4;
    total++;
    if (in_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", in_ready);
    else pass_cnt++;
    total++;
    if (occupancy !== 4'd3) $display("FAIL full_occ: got %0d want 3", occupancy);
    else pass_cnt++;
    step(); step();
    total++;
    if (out_data !== 32'd19 || out_valid !== 1'b1)
      $display("FAIL hold_data: got %0d/%b want 19/1", out_data, out_valid);
    else pass_cnt++;
    total++;
    if (occupancy !== 4'd3) $display("FAIL hold_occ: got %0d want 3", occupancy);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      xin = in_valid & in_ready;
      if (out_valid) got.push_back(out_data);
      step();
      if (xin) in_valid = 1'b0;
    end
    total++;
    if (got.size() != 4) $display("FAIL b2b_count: got %0d want 4", got.size());
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= got.size())
        $display("FAIL b2b_item%0d: got none want %0d", k, exp_v[k]);
      else if (got[k] !== exp_v[k])
        $display("FAIL b2b_item%0d: got %0d want %0d", k, got[k], exp_v[k]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_wrap_sat();
    out_ready = 1'b1;
    in_data = 32'hFFFF_FFF0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0002)
      $display("FAIL wrap_data: got %h/%b want 00000002/1", out_data, out_valid);
    else pass_cnt++;
    total++;
    if (out_ovf !== 1'b1) $display("FAIL wrap_ovf: got %b want 1", out_ovf);
    else pass_cnt++;
    total++;
    if (s_out_valid !== 1'b1 || s_out_data !== 32'hFFFF_FFFF)
      $display("FAIL sat_data: got %h/%b want ffffffff/1", s_out_data, s_out_valid);
    else pass_cnt++;
    total++;
    if (s_out_ovf !== 1'b1) $display("FAIL sat_ovf: got %b want 1", s_out_ovf);
    else pass_cnt++;
    step();
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_data = 32'd10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    in_data = 32'd20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    total++;
    if (occupancy !== 4'd2) $display("FAIL bubble_occ: got %0d want 2", occupancy);
    else pass_cnt++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL bubble_ready: got %b want 1", in_ready);
    else pass_cnt++;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd28)
      $display("FAIL bubble_head: got %0d/%b want 28/1", out_data, out_valid);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd38)
      $display("FAIL bubble_next: got %0d/%b want 38/1", out_data, out_valid);
    else pass_cnt++;
    step();
    total++;
    if (occupancy !== 4'd0) $display("FAIL bubble_drain: got %0d want 0", occupancy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_data = 32'(k);
      step();
    end
    in_valid = 1'b0;
    total++;
    if (occupancy !== 4'd3) $display("FAIL mid_full: got %0d want 3", occupancy);
    else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (occupancy !== 4'd0 || out_valid !== 1'b0)
      $display("FAIL mid_clear: got %0d/%b want 0/0", occupancy, out_valid);
    else pass_cnt++;
    out_ready = 1'b1;
    in_data = 32'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid) seen = 1'b1;
      else step();
    end
    total++;
    if (!seen) $display("FAIL mid_new: got timeout want 18");
    else if (out_data !== 32'd18) $display("FAIL mid_new: got %0d want 18", out_data);
    else pass_cnt++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL mid_extra: got %b want 0", out_valid);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap_sat();
    test_bubble();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
